chrono_lap_core: RTL and testbench

- Parametrised stopwatch core: BCD time-of-day chain with a configurable tick prescaler, two debounced buttons (start/stop and lap/clear), and a circular lap-capture memory.
- Sits between board buttons and the 7-segment display controller.
- Drives `digits` in the packed BCD format the display controller consumes.
- Adds lap/split hold, clear, overflow flag and lap readback to the single-button run/stop core.

---
 rtl/chrono_pkg.sv | 19 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/chrono_lap_core.sv | 152 +++++++++++++++
 tb/tb_chrono_lap_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chrono_pkg.sv
// Shared types and helpers for the chrono_lap_core stopwatch.
package chrono_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LAP_HOLD,
    STOP,
    CLEAR
  } state_t;

  typedef logic [3:0] bcd_t;

  // mm:ss.cc layout: tens-of-seconds and tens-of-minutes count 0..5
  function automatic int unsigned digit_radix(input int unsigned i);
    return (i == 3 || i == 5) ? 6 : 10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stable-level filter and
// a one-cycle pulse when the accepted level falls (button release).
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      evt   <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // sync2 differs from level here, so old level=1 means a release
        level <= sync2;
        cnt   <= '0;
        evt   <= level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chrono_lap_core.sv
// Stopwatch core: prescaled BCD mm:ss.cc chain, run/stop/lap/clear FSM,
// circular lap memory with registered newest-first readback.
module chrono_lap_core
  import chrono_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1000000,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned LAP_DEPTH  = 4,
  parameter int unsigned DEBOUNCE   = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_start,
  input  logic                           btn_lap,
  output logic [NUM_DIGITS*4-1:0]        digits,
  output logic                           running,
  output logic                           lap_hold,
  output logic                           overflow,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  input  logic [$clog2(LAP_DEPTH)-1:0]   lap_rd_idx,
  output logic [NUM_DIGITS*4-1:0]        lap_rd_data,
  output logic                           ready
);

  localparam int unsigned DW  = NUM_DIGITS * 4;
  localparam int unsigned PW  = $clog2(TICK_DIV);
  localparam int unsigned IW  = $clog2(LAP_DEPTH);
  localparam int unsigned LCW = $clog2(LAP_DEPTH + 1);

  state_t           state;
  state_t           state_nx;
  logic             start_evt;
  logic             lap_evt;
  logic             capture;
  logic             clear;
  logic             tick;
  logic [PW-1:0]    presc;
  logic [NUM_DIGITS:0] carry;
  logic [DW-1:0]    live;
  logic [DW-1:0]    freeze;
  logic [DW-1:0]    mem [LAP_DEPTH];
  logic [IW-1:0]    wr_ptr;
  logic [IW-1:0]    rd_addr;
  logic [LCW-1:0]   cnt_q;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_start (
    .clk(clk), .rst(rst), .btn(btn_start), .evt(start_evt)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_lap (
    .clk(clk), .rst(rst), .btn(btn_lap), .evt(lap_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // start is tested first everywhere, so a coincident lap is dropped
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    clear    = 1'b0;
    unique case (state)
      IDLE:     if (start_evt) state_nx = RUN;
      RUN: begin
        if (start_evt) state_nx = STOP;
        else if (lap_evt) begin
          state_nx = LAP_HOLD;
          capture  = 1'b1;
        end
      end
      LAP_HOLD: begin
        if (start_evt)    state_nx = STOP;
        else if (lap_evt) state_nx = RUN;
      end
      STOP: begin
        if (start_evt)    state_nx = RUN;
        else if (lap_evt) state_nx = CLEAR;
      end
      CLEAR: begin
        clear    = 1'b1;
        state_nx = IDLE;
      end
      default:  state_nx = IDLE;
    endcase
  end

  assign running  = (state == RUN) || (state == LAP_HOLD);
  assign lap_hold = (state == LAP_HOLD);
  assign tick     = running && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) presc <= '0;
    else if (running) presc <= tick ? '0 : presc + PW'(1);
  end

  assign carry[0] = tick;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam bcd_t DMAX = bcd_t'(digit_radix(i) - 1);
    bcd_t d;

    assign carry[i+1]     = carry[i] && (d == DMAX);
    assign live[i*4 +: 4] = d;

    always_ff @(posedge clk) begin
      if (rst || clear)  d <= '0;
      else if (carry[i]) d <= (d == DMAX) ? '0 : d + bcd_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear)            overflow <= 1'b0;
    else if (carry[NUM_DIGITS])  overflow <= 1'b1;
  end

  // live is the pre-edge value, so a same-edge increment is not captured
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAP_DEPTH; k++) mem[k] <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      freeze <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (capture) begin
      mem[wr_ptr] <= live;
      wr_ptr      <= wr_ptr + IW'(1);
      freeze      <= live;
      if (cnt_q != LCW'(LAP_DEPTH)) cnt_q <= cnt_q + LCW'(1);
    end
  end

  assign rd_addr = wr_ptr - IW'(1) - lap_rd_idx;

  always_ff @(posedge clk) begin
    if (rst)                               lap_rd_data <= '0;
    else if (LCW'(lap_rd_idx) < cnt_q)     lap_rd_data <= mem[rd_addr];
    else                                   lap_rd_data <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) ready <= 1'b0;
    else     ready <= 1'b1;
  end

  assign lap_count = cnt_q;
  assign digits    = lap_hold ? freeze : live;

endmodule

// File: tb/tb_chrono_lap_core.sv
// Scoreboard bench: a tick-counting reference model predicts every output
// each cycle; a separate negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_chrono_lap_core;

  localparam int unsigned TD   = 4;
  localparam int unsigned ND   = 8;
  localparam int unsigned LD   = 4;
  localparam int unsigned DB   = 3;
  localparam int unsigned MAXT = 36000000;
  localparam int unsigned LAT  = 2 + DB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, btn_start, btn_lap;
  logic [31:0]   digits, lap_rd_data;
  logic          running, lap_hold, overflow, ready;
  logic [2:0]    lap_count;
  logic [1:0]    lap_rd_idx;

  logic          s_rst, s_btn_start, s_btn_lap;
  logic [15:0]   s_digits, s_lap_rd_data;
  logic          s_running, s_lap_hold, s_overflow, s_ready;
  logic [1:0]    s_lap_count;
  logic          s_lap_rd_idx;
  bit            s_done = 1'b0;

  chrono_lap_core #(.TICK_DIV(TD), .NUM_DIGITS(ND), .LAP_DEPTH(LD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_lap(btn_lap),
    .digits(digits), .running(running), .lap_hold(lap_hold), .overflow(overflow),
    .lap_count(lap_count), .lap_rd_idx(lap_rd_idx), .lap_rd_data(lap_rd_data),
    .ready(ready)
  );

  chrono_lap_core #(.TICK_DIV(2), .NUM_DIGITS(4), .LAP_DEPTH(2), .DEBOUNCE(1)) dut_small (
    .clk(clk), .rst(s_rst), .btn_start(s_btn_start), .btn_lap(s_btn_lap),
    .digits(s_digits), .running(s_running), .lap_hold(s_lap_hold), .overflow(s_overflow),
    .lap_count(s_lap_count), .lap_rd_idx(s_lap_rd_idx), .lap_rd_data(s_lap_rd_data),
    .ready(s_ready)
  );

  typedef struct {
    logic [31:0] digits;
    logic        running;
    logic        hold;
    logic        ovf;
    logic [2:0]  cnt;
    logic [31:0] rd;
    logic        ready;
  } snap_t;

  typedef struct {
    int unsigned at;
    bit          s;
    bit          l;
  } ev_t;

  typedef struct {
    int unsigned at;
    logic [15:0] dg;
    logic        run;
    logic        ovf;
  } sm_t;

  snap_t       snap_q[$];
  ev_t         evq[$];
  sm_t         sm_q[$];
  logic [31:0] laps[$];
  int unsigned cyc = 0;
  int unsigned rc = 0;
  string       mode = "idle";
  logic [31:0] freeze_m = '0;
  logic [31:0] rd_m = '0;
  bit          ready_m = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic [31:0] to_bcd(input int unsigned t);
    int unsigned cc, s, m, h;
    cc = t % 100;
    s  = (t / 100) % 60;
    m  = (t / 6000) % 60;
    h  = (t / 360000) % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: time = running cycles / TD ticks, laps newest-first.
  always @(posedge clk) begin
    logic [31:0] pre_v;
    bit se, le;
    snap_t e;
    cyc++;
    if (rst) begin
      rc = 0; mode = "idle"; laps.delete(); evq.delete();
      freeze_m = '0; rd_m = '0; ready_m = 1'b0;
    end else begin
      ready_m = 1'b1;
      pre_v = to_bcd((rc / TD) % MAXT);
      rd_m = (int'(lap_rd_idx) < laps.size()) ? laps[lap_rd_idx] : '0;
      se = 1'b0; le = 1'b0;
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        if (evq[0].s) se = 1'b1;
        if (evq[0].l) le = 1'b1;
        void'(evq.pop_front());
      end
      if (mode == "clear") begin
        rc = 0; laps.delete(); mode = "idle";
      end else begin
        if (mode == "run" || mode == "hold") rc++;
        if (se) begin
          mode = (mode == "idle" || mode == "stop") ? "run" : "stop";
        end else if (le) begin
          if (mode == "run") begin
            laps.push_front(pre_v);
            if (laps.size() > LD) void'(laps.pop_back());
            freeze_m = pre_v;
            mode = "hold";
          end else if (mode == "hold") mode = "run";
          else if (mode == "stop") mode = "clear";
        end
      end
    end
    e.digits  = (mode == "hold") ? freeze_m : to_bcd((rc / TD) % MAXT);
    e.running = (mode == "run" || mode == "hold");
    e.hold    = (mode == "hold");
    e.ovf     = (rc / TD) >= MAXT;
    e.cnt     = 3'(laps.size());
    e.rd      = rd_m;
    e.ready   = ready_m;
    snap_q.push_back(e);
  end

  always @(negedge clk) begin
    snap_t e;
    sm_t   x;
    if (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      chk("digits", digits, e.digits);
      chk("running", 32'(running), 32'(e.running));
      chk("lap_hold", 32'(lap_hold), 32'(e.hold));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("lap_count", 32'(lap_count), 32'(e.cnt));
      chk("lap_rd_data", lap_rd_data, e.rd);
      chk("ready", 32'(ready), 32'(e.ready));
    end
    while (sm_q.size() > 0 && sm_q[0].at == cyc) begin
      x = sm_q.pop_front();
      chk("small_digits", 32'(s_digits), 32'(x.dg));
      chk("small_running", 32'(s_running), 32'(x.run));
      chk("small_overflow", 32'(s_overflow), 32'(x.ovf));
      chk("small_lap_hold", 32'(s_lap_hold), 32'(0));
      chk("small_lap_count", 32'(s_lap_count), 32'(0));
      chk("small_lap_rd_data", 32'(s_lap_rd_data), 32'(0));
      chk("small_ready", 32'(s_ready), 32'(1));
    end
  end

  // Raise, optionally bounce 0-1-0-1, then release and hold low.
  task automatic press(input bit s, input bit l, input bit bounce);
    ev_t ev;
    if (s) btn_start = 1'b1;
    if (l) btn_lap = 1'b1;
    repeat (6) step();
    if (bounce) begin
      for (int i = 0; i < 4; i++) begin
        if (s) btn_start = i[0];
        if (l) btn_lap = i[0];
        step();
      end
    end
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    ev.at = cyc + LAT; ev.s = s; ev.l = l;
    evq.push_back(ev);
    repeat (8) step();
  endtask

  task automatic wait_ticks(input int unsigned target, input int unsigned limit);
    int unsigned g;
    g = 0;
    while ((rc / TD) < target && g < limit) begin
      step();
      g++;
    end
    if ((rc / TD) < target) begin
      checks++; errors++;
      $display("FAIL wait_ticks: reached %0d required %0d", rc / TD, target);
    end
  endtask

  initial begin
    sm_t x;
    logic [31:0] v;
    int unsigned n;
    s_rst = 1'b1; s_btn_start = 1'b0; s_btn_lap = 1'b0; s_lap_rd_idx = 1'b0;
    repeat (3) step();
    s_rst = 1'b0;
    repeat (4) step();
    s_btn_start = 1'b1;
    repeat (4) step();
    s_btn_start = 1'b0;
    n = cyc;
    x.at = n + 3;             x.dg = 16'h0000; x.run = 1'b0; x.ovf = 1'b0; sm_q.push_back(x);
    x.at = n + 4;             x.run = 1'b1; sm_q.push_back(x);
    v = to_bcd(5999);
    x.at = n + 4 + 2 * 5999;  x.dg = v[15:0]; sm_q.push_back(x);
    x.at = n + 4 + 2 * 6000;  x.dg = 16'h0000; x.ovf = 1'b1; sm_q.push_back(x);
    v = to_bcd(1);
    x.at = n + 4 + 2 * 6001;  x.dg = v[15:0]; sm_q.push_back(x);
    repeat (12020) step();
    s_done = 1'b1;
  end

  initial begin
    int unsigned r;
    rst = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; lap_rd_idx = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    press(1, 0, 0);
    repeat (44) step();
    press(1, 0, 1);
    repeat (10) step();
    press(1, 0, 0);

    wait_ticks(117, 2000);
    press(0, 1, 0);
    repeat (30) step();
    press(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(4, 40)) step();
      press(0, 1, 0);
      repeat ($urandom_range(0, 20)) step();
      press(0, 1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      lap_rd_idx = 2'(k);
      repeat (3) step();
    end

    wait_ticks(6010, 30000);
    press(1, 1, 0);
    repeat (10) step();
    press(0, 1, 0);
    repeat (6) step();

    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(0, 5);
      lap_rd_idx = 2'($urandom_range(0, 3));
      press(r < 3 || r == 5, r >= 3, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 30)) step();
    end

    btn_lap = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    btn_lap = 1'b0;
    step();
    rst = 1'b0;
    repeat (10) step();
    press(1, 0, 0);
    repeat (20) step();

    for (int g = 0; g < 30000 && !s_done; g++) step();
    chk("small_done", 32'(s_done), 32'(1));
    repeat (2) step();
    chk("small_pending", sm_q.size(), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
